// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider: 2N-bit dividend / N-bit divisor.
// One quotient bit per cycle, valid/ready on both sides.
module seq_divider #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero
);

  localparam int CW = $clog2(2*N) + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t         r_state;
  logic [2*N-1:0] r_q;
  logic [N-1:0]   r_r;
  logic [N-1:0]   r_d;
  logic [CW-1:0]  r_cnt;
  logic           r_zero;
  logic           r_in_ready;
  logic           r_out_valid;
  logic           r_dbz;

  // Partial remainder never exceeds the divisor, so R fits in N bits;
  // the trial value T needs the extra top bit.
  logic [N:0]     w_t;
  logic           w_ge;
  logic [N-1:0]   w_diff;
  logic           w_last;

  assign w_t    = {r_r, r_q[2*N-1]};
  assign w_ge   = w_t >= {1'b0, r_d};
  assign w_diff = w_t[N-1:0] - r_d;
  assign w_last = r_cnt == CW'(2*N);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_q         <= '0;
      r_r         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_zero      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_q        <= dividend;
            r_d        <= divisor;
            r_r        <= '0;
            r_cnt      <= '0;
            r_zero     <= divisor == '0;
            r_dbz      <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= CALC;
          end
        end
        CALC: begin
          if (r_zero) begin
            // Divide-by-zero: present all-ones quotient, low dividend half
            r_q         <= '1;
            r_r         <= r_q[N-1:0];
            r_dbz       <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else if (w_last) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_q   <= {r_q[2*N-2:0], w_ge};
            r_r   <= w_ge ? w_diff : w_t[N-1:0];
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign quotient    = r_q;
  assign remainder   = r_r;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized bench for seq_divider (N=16).
// Expected results are queued at accept and compared when out_valid rises.
module tb_seq_divider;

  localparam int N = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2*N-1:0] dividend;
  logic [N-1:0]  divisor;
  logic          out_valid;
  logic          out_ready;
  logic [2*N-1:0] quotient;
  logic [N-1:0]  remainder;
  logic          div_by_zero;

  always #5 clk = ~clk;

  seq_divider #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [31:0] q;
    logic [15:0] r;
    logic        z;
    int          lat;
    logic [31:0] a;
    logic [15:0] b;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [15:0] b,
                        input int stall);
    exp_t        e;
    exp_t        p;
    int          lat;
    logic        busy_ok;
    logic        hold_ok;
    logic [31:0] hq;
    logic [15:0] hr;
    logic [63:0] prod;
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    e.a   = a;
    e.b   = b;
    e.z   = (b == 16'd0);
    e.q   = e.z ? 32'hFFFF_FFFF : a / {16'd0, b};
    e.r   = e.z ? a[15:0] : 16'(a % {16'd0, b});
    e.lat = e.z ? 1 : 33;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = 16'($urandom);
    lat      = 0;
    busy_ok  = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(e.lat));
    check("in_ready_busy", 64'(busy_ok), 64'd1);
    check("in_ready_done", 64'(in_ready), 64'd0);
    if (stall > 0) begin
      hq       = quotient;
      hr       = remainder;
      hold_ok  = 1'b1;
      in_valid = 1'b1;
      dividend = 32'd77;
      divisor  = 16'd5;
      repeat (stall) begin
        @(posedge clk);
        #1;
        if (!out_valid || in_ready || quotient !== hq ||
            remainder !== hr) hold_ok = 1'b0;
      end
      check("stall_hold", 64'(hold_ok), 64'd1);
      out_ready = 1'b1;
    end
    p = sb.pop_front();
    check("quotient", 64'(quotient), 64'(p.q));
    check("remainder", 64'(remainder), 64'(p.r));
    check("div_by_zero", 64'(div_by_zero), 64'(p.z));
    if (p.b != 16'd0) begin
      prod = 64'(quotient) * 64'(p.b) + 64'(remainder);
      check("invariant", prod, 64'(p.a));
      check("rem_lt_div", 64'(remainder < p.b), 64'd1);
    end
    @(posedge clk);
    #1;
    check("consumed_valid", 64'(out_valid), 64'd0);
    check("consumed_ready", 64'(in_ready), 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    logic        quiet;
    logic [15:0] rb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_quotient", 64'(quotient), 64'd0);
    check("rst_remainder", 64'(remainder), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    rst = 1'b0;

    run_op(32'd1000, 16'd7, 0);
    run_op(32'hFFFF_FFFF, 16'hFFFF, 0);
    run_op(32'd5, 16'd9, 0);
    run_op(32'h1234_5678, 16'd0, 0);
    run_op(32'd0, 16'd3, 0);
    run_op(32'd100, 16'd3, 10);

    // Reset on the 10th CALC cycle discards the in-flight operation
    @(negedge clk);
    dividend = 32'd1000;
    divisor  = 16'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    quiet = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid || !in_ready) quiet = 1'b0;
    end
    check("midrst_no_stale", 64'(quiet), 64'd1);
    run_op(32'd81, 16'd9, 0);

    for (int i = 0; i < 150; i++) begin
      unique case (i % 6)
        0: rb = 16'd1;
        1: rb = 16'hFFFF;
        2: rb = 16'($urandom_range(1, 15));
        default: rb = 16'($urandom_range(1, 65535));
      endcase
      run_op($urandom, rb, (i % 17 == 5) ? 3 : 0);
    end
    run_op($urandom, 16'd0, 0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
